// File: rtl/hyst_pkg.sv
// Shared definitions for the systolic-array pass sequencer.
//   state_t      : sequencer state encoding
//   drain_cycles : cycles needed for results to ripple out of the delay chain
package hyst_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int unsigned drain_cycles(input int unsigned vector);
        return 2 * vector - 1;
    endfunction

endpackage

// File: rtl/hyst_skew_lane_decode.sv
// Per-lane skewed feed-enable decode: lane i is active for feed counts
// i .. k_len+i-1, so lane i enters the array i cycles after lane 0.
//   c_i       : feed counter (K_W+1 bits so k_len+i never wraps)
//   k_len_i   : latched reduction length
//   lane_en_o : raw per-lane enables (gated by the caller)
module hyst_skew_lane_decode #(
    parameter int unsigned VECTOR = 2,
    parameter int unsigned K_W    = 8
) (
    input  logic [K_W:0]        c_i,
    input  logic [K_W-1:0]      k_len_i,
    output logic [VECTOR-1:0]   lane_en_o
);

    localparam int unsigned CW = K_W + 1;

    always_comb begin
        lane_en_o = '0;
        for (int unsigned i = 0; i < VECTOR; i++) begin
            lane_en_o[i] = (c_i >= CW'(i)) && (c_i < ({1'b0, k_len_i} + CW'(i)));
        end
    end

endmodule

// File: rtl/hyst_array_seq_ctrl.sv
// Sequencer for one operand pass through the systolic array.
// On start it clears the accumulators, issues k_len operand reads with
// per-lane skewed feed enables, waits for the delay chain to drain, then
// pulses done.
//   clk, rst : clock, synchronous active-high reset
//   start    : pass request (sampled only in IDLE), k_len latched with it
//   stall    : backpressure, honoured only while feeding
//   busy     : high outside IDLE
//   acc_clr  : one-cycle accumulator clear
//   rd_en    : operand-buffer read strobe, rd_addr = feed count
//   lane_en  : per-lane feed enables into the delay chain
//   done     : one-cycle completion pulse
module hyst_array_seq_ctrl
    import hyst_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 16,
    parameter int unsigned VECTOR    = 2,
    parameter int unsigned K_W       = 8,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K_W-1:0]    k_len,
    input  logic              stall,
    output logic              busy,
    output logic              acc_clr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [VECTOR-1:0] lane_en,
    output logic              done
);

    if (VECTOR < 2 || ADDR_W < K_W || REG_WIDTH < 1) begin : g_bad_params
        $error("hyst_array_seq_ctrl: illegal parameter combination");
    end

    localparam int unsigned CW = K_W + 1;
    localparam int unsigned DW = $clog2(2 * VECTOR);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(drain_cycles(VECTOR) - 1);
    localparam logic [CW-1:0] SKEW_TAIL  = CW'(VECTOR - 2);

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [DW-1:0]   d_q, d_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [CW-1:0]   feed_last;
    logic            feed_go;
    logic [VECTOR-1:0] lane_raw;

    // Last feed count: the last lane needs VECTOR-1 extra cycles to see k_len operands.
    assign feed_last = {1'b0, k_q} + SKEW_TAIL;
    assign feed_go   = (state_q == FEED) && !stall;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_d     = k_len;
                        state_d = CLEAR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLEAR: begin
                c_d     = '0;
                state_d = FEED;
            end
            FEED: begin
                if (!stall) begin
                    if (c_q == feed_last) begin
                        d_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (d_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            k_q     <= k_d;
        end
    end

    hyst_skew_lane_decode #(
        .VECTOR (VECTOR),
        .K_W    (K_W)
    ) u_lane_decode (
        .c_i       (c_q),
        .k_len_i   (k_q),
        .lane_en_o (lane_raw)
    );

    assign busy    = (state_q != IDLE);
    assign acc_clr = (state_q == CLEAR);
    assign done    = (state_q == DONE);
    assign rd_en   = feed_go && (c_q < {1'b0, k_q});
    assign rd_addr = (state_q == FEED) ? ADDR_W'(c_q[K_W-1:0]) : '0;
    assign lane_en = feed_go ? lane_raw : '0;

endmodule
